// File: rtl/ooo_dispatch_buffer.sv
// ooo_dispatch_buffer: routes decoded packets into per-functional-unit FIFOs,
// tags each accepted packet with a program-order sequence number, and lets
// every execute unit drain its own queue through an independent valid/ready.
module ooo_dispatch_buffer #(
  parameter int NUM_FU    = 5,
  parameter int DEPTH     = 4,
  parameter int PAYLOAD_W = 128,
  parameter int SEQ_W     = 6,
  localparam int FU_W     = $clog2(NUM_FU),
  localparam int CNT_W    = $clog2(DEPTH) + 1
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        flush,
  input  logic                        dec_valid,
  output logic                        dec_ready,
  input  logic [FU_W-1:0]             dec_fu,
  input  logic                        dec_halt,
  input  logic [PAYLOAD_W-1:0]        dec_payload,
  output logic [NUM_FU-1:0]           fu_valid,
  input  logic [NUM_FU-1:0]           fu_ready,
  output logic [NUM_FU*PAYLOAD_W-1:0] fu_payload,
  output logic [NUM_FU*SEQ_W-1:0]     fu_seq,
  output logic [NUM_FU*CNT_W-1:0]     fu_count,
  output logic                        halted
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PAYLOAD_W-1:0] r_pay   [NUM_FU][DEPTH];
  logic [SEQ_W-1:0]     r_tag   [NUM_FU][DEPTH];
  logic [PTR_W-1:0]     r_wptr  [NUM_FU];
  logic [PTR_W-1:0]     r_rptr  [NUM_FU];
  logic [CNT_W-1:0]     r_count [NUM_FU];
  logic [SEQ_W-1:0]     r_seq;
  logic                 r_halted;

  logic                 w_sel_full;
  logic                 w_in_range;
  logic                 w_accept;
  logic [NUM_FU-1:0]    w_enq;
  logic [NUM_FU-1:0]    w_deq;
  logic [NUM_FU-1:0]    w_valid;

  // Decode the target channel; out-of-range indices never count as full.
  always_comb begin
    w_sel_full = 1'b0;
    w_in_range = 1'b0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (dec_fu == FU_W'(i)) begin
        w_in_range = 1'b1;
        if (r_count[i] == CNT_W'(DEPTH)) w_sel_full = 1'b1;
      end
    end
  end

  // A full channel blocks even while draining: no same-cycle dequeue credit.
  assign dec_ready = !r_halted && !flush && !w_sel_full;
  assign w_accept  = dec_valid && dec_ready;
  assign halted    = r_halted;

  // Per-channel enqueue/dequeue strobes and head-of-queue outputs.
  always_comb begin
    w_enq      = '0;
    w_valid    = '0;
    fu_payload = '0;
    fu_seq     = '0;
    fu_count   = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      w_enq[i]                             = w_accept && (dec_fu == FU_W'(i));
      w_valid[i]                           = (r_count[i] != '0);
      fu_payload[i*PAYLOAD_W +: PAYLOAD_W] = r_pay[i][r_rptr[i]];
      fu_seq[i*SEQ_W +: SEQ_W]             = r_tag[i][r_rptr[i]];
      fu_count[i*CNT_W +: CNT_W]           = r_count[i];
    end
  end

  assign fu_valid = w_valid;
  assign w_deq    = w_valid & fu_ready;

  // FIFO storage, pointers, counts, sequence tag and halt flag.
  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NUM_FU; i++) begin
        for (int j = 0; j < DEPTH; j++) begin
          r_pay[i][j] <= '0;
          r_tag[i][j] <= '0;
        end
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
      r_seq    <= '0;
      r_halted <= 1'b0;
    end else if (flush) begin
      // Storage is left stale; only the bookkeeping is cleared.
      for (int i = 0; i < NUM_FU; i++) begin
        r_wptr[i]  <= '0;
        r_rptr[i]  <= '0;
        r_count[i] <= '0;
      end
      r_halted <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (w_enq[i]) begin
          r_pay[i][r_wptr[i]] <= dec_payload;
          r_tag[i][r_wptr[i]] <= r_seq;
          r_wptr[i]           <= r_wptr[i] + 1'b1;
        end
        if (w_deq[i]) r_rptr[i] <= r_rptr[i] + 1'b1;
        case ({w_enq[i], w_deq[i]})
          2'b10:   r_count[i] <= r_count[i] + 1'b1;
          2'b01:   r_count[i] <= r_count[i] - 1'b1;
          default: r_count[i] <= r_count[i];
        endcase
      end
      // Dropped (out-of-range) packets neither consume a tag nor halt.
      if (w_accept && w_in_range) begin
        r_seq <= r_seq + 1'b1;
        if (dec_halt) r_halted <= 1'b1;
      end
    end
  end

endmodule

// File: doc/ooo_dispatch_buffer.md
# ooo_dispatch_buffer

Parametrised decode-to-execute dispatch stage for the out-of-order core. It replaces the flat decode/execute signal bundle with per-functional-unit FIFOs. Each decoded instruction packet is routed by its scalar functional-unit type into one of `NUM_FU` queues and tagged with a program-order sequence number. Each execute unit drains its queue through an independent valid/ready handshake, which decouples decode stalls from individual unit stalls.

## Interface
Reset is synchronous and active-high; the block has one clock.

**Parameters**
- `NUM_FU`, default 5: number of functional-unit channels (arith, mult, div, loadstore, branch/jump).
- `DEPTH`, default 4: entries per channel FIFO. Must be a power of two and ≥ 2.
- `PAYLOAD_W`, default 128: width of the decoded packet (operands, immediate, pc, control structs).
- `SEQ_W`, default 6: sequence-tag width.

**Ports** (derived widths: `FU_W = $clog2(NUM_FU)`, `CNT_W = $clog2(DEPTH)+1`)
- `CLK` in 1: clock.
- `RST` in 1: synchronous active-high reset.
- `flush` in 1: squash all queued instructions.
- `dec_valid` in 1: decode presents a packet.
- `dec_ready` out 1: buffer accepts the packet this cycle.
- `dec_fu` in FU_W: target channel index.
- `dec_halt` in 1: packet is a halt instruction.
- `dec_payload` in PAYLOAD_W: decoded packet.
- `fu_valid` out NUM_FU: head entry valid, one bit per channel.
- `fu_ready` in NUM_FU: unit takes the head, one bit per channel.
- `fu_payload` out NUM_FU*PAYLOAD_W: head payloads; channel i occupies bits [i*PAYLOAD_W +: PAYLOAD_W].
- `fu_seq` out NUM_FU*SEQ_W: head sequence tags.
- `fu_count` out NUM_FU*CNT_W: occupancy per channel.
- `halted` out 1: a halt has been accepted.

## Operation
- **Accept:** an enqueue occurs when `dec_valid && dec_ready`.
- **`dec_ready`:** equals `!halted && !flush && (dec_fu >= NUM_FU || count[dec_fu] < DEPTH)`.
  - It does not credit a same-cycle dequeue, so a full channel blocks even while it is draining.
- **Out-of-range `dec_fu`** (≥ NUM_FU): the packet is consumed and dropped. No FIFO write occurs, the sequence counter does not advance, and `halted` is not affected.
- **Sequence counter:**
  - Reset value is 0.
  - The accepted packet is stored with the current value, then the counter increments modulo 2^SEQ_W.
  - Flush does not alter the counter.
- **Channel FIFO:**
  - Each channel is a circular buffer with write pointer, read pointer and count; pointers wrap at DEPTH.
  - `fu_valid[i] = (count[i] != 0)`.
  - `fu_payload`/`fu_seq` show the entry at the read pointer.
  - A dequeue occurs on `fu_valid[i] && fu_ready[i]`.
- **Simultaneous enqueue and dequeue on one channel:** both take effect and the count is unchanged. This is legal only when count is between 1 and DEPTH-1, because `dec_ready` already excludes the full case.
- **Halt:** accepting a packet with `dec_halt=1` stores it normally and sets `halted` from the next cycle. While `halted` is set, `dec_ready` stays 0. `halted` clears only on flush or reset.
- **Flush:**
  - All counts and pointers go to 0 and `halted` goes to 0, effective next cycle.
  - No enqueue occurs in the flush cycle.
  - Dequeue handshakes in the flush cycle are honoured by the unit, but the buffer clears regardless.
- **Reset:**
  - Counts, pointers, `halted` and the sequence counter go to 0.
  - Storage goes to 0, so `fu_payload = 0` and `fu_seq = 0`.
  - All `fu_valid` bits are 0 and `dec_ready` is 1 in the cycle after reset deasserts.

## Timing
- Enqueue-to-visible latency is 1 cycle: a packet written at edge N appears on an empty channel's head after edge N.
- A dequeue at edge N exposes the next entry after edge N, giving 1 entry/cycle/channel throughput.
- `dec_ready` is combinational from `flush`, `halted`, `dec_fu` and count. `fu_*` outputs are registered-state driven with no combinational path from `fu_ready`.
- All channels operate concurrently and independently.
- `RST` has priority over `flush`; `flush` has priority over enqueue and dequeue.

## Test plan
- **Reset:** hold RST 2 cycles, release -> `fu_valid=0`, `fu_count=0`, `halted=0`, `dec_ready=1`, `fu_seq=0`.
- **Routing and tags:** enqueue payloads 0xA0..0xA3 to channels 0,2,0,4 -> ch0 holds seq 0,2; ch2 holds seq 1; ch4 holds seq 3. Each appears one cycle after its write.
- **Full and wrap:** `DEPTH=4`, `fu_ready[1]=0`, fill ch1 with 4 packets -> fifth attempt sees `dec_ready=0`. Then drain 2, refill 2 -> order is preserved across the pointer wrap. With SEQ_W=6, sending 70 packets wraps the tag 63 -> 0.
- **Simultaneous enqueue/dequeue:** ch3 at count 2, enqueue and dequeue in the same cycle -> count stays 2 and the head advances.
- **Halt:** accept a `dec_halt` packet on ch0 -> `halted=1` the next cycle and `dec_ready=0` for 10 cycles. Then pulse flush -> `halted=0`, all counts 0, `dec_ready=1`.
- **Flush mid-operation:** channels partly full plus an enqueue attempted in the flush cycle -> the enqueue is not accepted and all `fu_valid=0` the next cycle. The sequence counter continues from its pre-flush value.
